// File: rtl/dram_arbiter_pkg.sv
// Shared constants and FSM encoding for the DRAM arbiter and the DRAM controller.
package dram_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB,
    GNT_DW,
    GNT_DR,
    GNT_IR,
    RECOVER
  } state_t;

  localparam int BLOCK_SIZE_I_DEF   = 16;
  localparam int BLOCK_SIZE_D_DEF   = 8;
  localparam int RECOVER_CYCLES_DEF = 3;

endpackage

// File: rtl/dram_arbiter.sv
// Arbitrates I_Cache fills, D_Cache fills and D_Cache write-backs onto one DRAM controller.
// state   | meaning
// ARB     | idle, choosing the next burst
// GNT_DW  | D_Cache write-back burst in progress
// GNT_DR  | D_Cache fill burst in progress
// GNT_IR  | I_Cache fill burst in progress
// RECOVER | idle gap after a burst before the next grant
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE_I   = BLOCK_SIZE_I_DEF,
  parameter int BLOCK_SIZE_D   = BLOCK_SIZE_D_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        ic_rd_req,
  input  logic [31:0] ic_rd_addr,
  output logic [31:0] ic_rd_data,
  output logic        ic_rd_val,
  input  logic        dc_wr_req,
  input  logic [31:0] dc_wr_addr,
  input  logic [31:0] dc_wr_data,
  output logic        dc_wr_val,
  input  logic        dc_rd_req,
  input  logic [31:0] dc_rd_addr,
  output logic [31:0] dc_rd_data,
  output logic        dc_rd_val,
  output logic        dram_wr_req,
  output logic [31:0] dram_wr_addr,
  output logic [31:0] dram_wr_data,
  input  logic        dram_wr_val,
  output logic        idrd_req,
  output logic        dram_rd_req,
  output logic [31:0] dram_rd_addr,
  input  logic [31:0] dram_rd_data,
  input  logic        dram_rd_val
);

  localparam logic [3:0] LAST_I   = 4'(BLOCK_SIZE_I - 1);
  localparam logic [3:0] LAST_D   = 4'(BLOCK_SIZE_D - 1);
  localparam logic [7:0] REC_LOAD = 8'(RECOVER_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  beat_cnt;
  logic [7:0]  rec_cnt;
  logic        last_i;
  logic        strobe, last_beat, d_want;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    strobe     = 1'b0;
    last_beat  = 1'b0;
    d_want     = dc_wr_req | dc_rd_req;
    case (state)
      ARB: begin
        // On contention the side that did not win last time goes next.
        if (ic_rd_req && (!d_want || !last_i)) next_state = GNT_IR;
        else if (d_want)                       next_state = dc_wr_req ? GNT_DW : GNT_DR;
      end
      GNT_DW: begin
        strobe    = dram_wr_val;
        last_beat = strobe && (beat_cnt == LAST_D);
      end
      GNT_DR: begin
        strobe    = dram_rd_val;
        last_beat = strobe && (beat_cnt == LAST_D);
      end
      GNT_IR: begin
        strobe    = dram_rd_val;
        last_beat = strobe && (beat_cnt == LAST_I);
      end
      RECOVER: begin
        if (rec_cnt == 8'd0) next_state = ARB;
      end
      default: next_state = ARB;
    endcase
    if (last_beat) next_state = RECOVER;

    // Requests drop with the final strobe so the controller never starts a second burst.
    dram_wr_req = (state == GNT_DW) && !last_beat;
    dram_rd_req = ((state == GNT_DR) || (state == GNT_IR)) && !last_beat;
    ic_rd_val   = dram_rd_val && (state == GNT_IR);
    dc_rd_val   = dram_rd_val && (state == GNT_DR);
    dc_wr_val   = dram_wr_val && (state == GNT_DW);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      beat_cnt <= 4'd0;
      rec_cnt  <= 8'd0;
      last_i   <= 1'b1;
      idrd_req <= 1'b0;
    end else begin
      if (next_state == ARB && state != ARB) beat_cnt <= 4'd0;
      else if (strobe)                       beat_cnt <= beat_cnt + 4'd1;

      if (last_beat)                                rec_cnt <= REC_LOAD;
      else if (state == RECOVER && rec_cnt != 8'd0) rec_cnt <= rec_cnt - 8'd1;

      if (state == ARB && next_state != ARB) begin
        last_i <= (next_state == GNT_IR);
        if (next_state == GNT_IR)      idrd_req <= 1'b1;
        else if (next_state == GNT_DR) idrd_req <= 1'b0;
      end
    end
  end

  assign dram_wr_addr = dc_wr_addr;
  assign dram_wr_data = dc_wr_data;
  assign dram_rd_addr = idrd_req ? ic_rd_addr : dc_rd_addr;
  assign ic_rd_data   = dram_rd_data;
  assign dc_rd_data   = dram_rd_data;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a burst-level model.
module tb_dram_arbiter;

  logic        clock, rst;
  logic        ic_rd_req, dc_wr_req, dc_rd_req;
  logic [31:0] ic_rd_addr, dc_wr_addr, dc_wr_data, dc_rd_addr;
  logic [31:0] ic_rd_data, dc_rd_data;
  logic        ic_rd_val, dc_wr_val, dc_rd_val;
  logic        dram_wr_req, dram_rd_req, idrd_req;
  logic [31:0] dram_wr_addr, dram_wr_data, dram_rd_addr, dram_rd_data;
  logic        dram_wr_val, dram_rd_val;

  dram_arbiter dut (
    .clock(clock), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_data(ic_rd_data), .ic_rd_val(ic_rd_val),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_val(dc_wr_val),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_data(dc_rd_data), .dc_rd_val(dc_rd_val),
    .dram_wr_req(dram_wr_req), .dram_wr_addr(dram_wr_addr), .dram_wr_data(dram_wr_data),
    .dram_wr_val(dram_wr_val), .idrd_req(idrd_req), .dram_rd_req(dram_rd_req),
    .dram_rd_addr(dram_rd_addr), .dram_rd_data(dram_rd_data), .dram_rd_val(dram_rd_val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Burst-level model: current grant (0 none, 1 D write, 2 D fill, 3 I fill),
  // words moved so far, idle cycles still owed after a burst.
  int  g = 0, words = 0, idle_left = 0;
  bit  last_was_i = 1'b1, m_idrd = 1'b0;
  bit  m_strobe, m_fin, d_any;
  bit  seen_ic, seen_dcr, seen_dcw, prev_busy;
  int  log_type[$];
  int  log_cyc[$];

  function automatic int bsize(input int gg);
    return (gg == 3) ? 16 : 8;
  endfunction

  always @(negedge clock) begin
    cyc_n++;
    if (!rst) begin
      g = 0; words = 0; idle_left = 0; last_was_i = 1'b1; m_idrd = 1'b0;
    end
    m_strobe = (g == 1) ? dram_wr_val : dram_rd_val;
    m_fin    = (g != 0) && m_strobe && (words == bsize(g) - 1);

    chk("wr_req",  dram_wr_req, (g == 1) && !m_fin);
    chk("rd_req",  dram_rd_req, (g == 2 || g == 3) && !m_fin);
    chk("idrd",    idrd_req, m_idrd);
    chk("ic_val",  ic_rd_val, dram_rd_val && g == 3);
    chk("dcr_val", dc_rd_val, dram_rd_val && g == 2);
    chk("dcw_val", dc_wr_val, dram_wr_val && g == 1);
    chk("rd_addr", dram_rd_addr, m_idrd ? ic_rd_addr : dc_rd_addr);
    chk("wr_addr", dram_wr_addr, dc_wr_addr);
    chk("wr_data", dram_wr_data, dc_wr_data);
    chk("ic_data", ic_rd_data, dram_rd_data);
    chk("dc_data", dc_rd_data, dram_rd_data);

    if ((dram_wr_req || dram_rd_req) && !prev_busy) begin
      log_type.push_back(dram_wr_req ? 1 : (idrd_req ? 3 : 2));
      log_cyc.push_back(cyc_n);
    end
    prev_busy = dram_wr_req || dram_rd_req;
    seen_ic = ic_rd_val; seen_dcr = dc_rd_val; seen_dcw = dc_wr_val;

    if (rst) begin
      d_any = dc_wr_req || dc_rd_req;
      if (g != 0) begin
        if (m_strobe) words++;
        if (m_fin) begin g = 0; words = 0; idle_left = 3; end
      end else if (idle_left > 0) begin
        idle_left--;
      end else if (ic_rd_req && (!d_any || !last_was_i)) begin
        g = 3; m_idrd = 1'b1; last_was_i = 1'b1;
      end else if (d_any) begin
        g = dc_wr_req ? 1 : 2;
        if (g == 2) m_idrd = 1'b0;
        last_was_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    dram_rd_data = $urandom;
  endtask

  task automatic wait_count(input int sel, input int n, input int limit, output int got);
    got = 0;
    for (int k = 0; k < limit && got < n; k++) begin
      @(negedge clock);
      case (sel)
        0:       got += int'(ic_rd_val);
        1:       got += int'(dc_rd_val);
        default: got += int'(dc_wr_val);
      endcase
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
  endtask

  int got;
  int ic_cnt, dr_cnt, dw_cnt;

  initial begin
    rst = 1'b0;
    ic_rd_req = 0; dc_wr_req = 0; dc_rd_req = 0;
    ic_rd_addr = 0; dc_wr_addr = 0; dc_rd_addr = 0; dc_wr_data = 32'h1234_5678;
    dram_rd_data = 0; dram_wr_val = 1'b1; dram_rd_val = 1'b1;

    // Reset state with strobes active: nothing may leak through.
    repeat (3) @(negedge clock);
    chk("rst_rd_req", dram_rd_req, 0);
    chk("rst_wr_req", dram_wr_req, 0);
    chk("rst_ic_val", ic_rd_val, 0);
    chk("rst_idrd",   idrd_req, 0);
    tick(); rst = 1'b1;

    // I-only fill at 0x100.
    tick(); ic_rd_req = 1; ic_rd_addr = 32'h100;
    @(negedge clock);
    chk("i_arb_no_req", dram_rd_req, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("i_val", ic_rd_val, 1);
      chk("i_dc_val", dc_rd_val, 0);
      chk("i_req", dram_rd_req, i != 15);
      if (i == 0) begin
        chk("i_idrd", idrd_req, 1);
        chk("i_addr", dram_rd_addr, 32'h100);
      end
    end
    tick(); ic_rd_req = 0;
    repeat (6) tick();

    // D write-back at 0x40, no second burst afterwards.
    log_type.delete(); log_cyc.delete();
    dc_wr_req = 1; dc_wr_addr = 32'h40;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("dw_val", dc_wr_val, 1);
      chk("dw_req", dram_wr_req, i != 7);
      chk("dw_addr", dram_wr_addr, 32'h40);
    end
    tick(); dc_wr_req = 0;
    repeat (8) tick();
    chk("dw_one_burst", log_type.size(), 1);

    // Contention straight after reset: D fill first, then alternate.
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    log_type.delete(); log_cyc.delete();
    ic_rd_req = 1; ic_rd_addr = 32'h200; dc_rd_req = 1; dc_rd_addr = 32'h80;
    repeat (60) tick();
    chk("contend_bursts", log_type.size() >= 4, 1);
    chk("contend_0", log_type.size() > 0 ? log_type[0] : 0, 2);
    chk("contend_1", log_type.size() > 1 ? log_type[1] : 0, 3);
    chk("contend_2", log_type.size() > 2 ? log_type[2] : 0, 2);
    chk("contend_3", log_type.size() > 3 ? log_type[3] : 0, 3);
    chk("contend_gap", log_cyc.size() > 1 ? log_cyc[1] - log_cyc[0] : 0, 12);
    ic_rd_req = 0; dc_rd_req = 0;
    repeat (25) tick();

    // D write and read together: write-back first.
    log_type.delete(); log_cyc.delete();
    dc_wr_req = 1; dc_rd_req = 1; dc_wr_addr = 32'h500; dc_rd_addr = 32'h600;
    wait_count(2, 8, 40, got);
    chk("wr_rd_words_w", got, 8);
    tick(); dc_wr_req = 0;
    wait_count(1, 8, 40, got);
    chk("wr_rd_words_r", got, 8);
    tick(); dc_rd_req = 0;
    repeat (6) tick();
    chk("wr_rd_bursts", log_type.size(), 2);
    chk("wr_rd_first", log_type.size() > 0 ? log_type[0] : 0, 1);
    chk("wr_rd_second", log_type.size() > 1 ? log_type[1] : 0, 2);

    // Reset after the 5th I word aborts at once; refill restarts from word 0.
    ic_rd_req = 1; ic_rd_addr = 32'h300;
    wait_count(0, 5, 40, got);
    chk("abort_pre", got, 5);
    #2 rst = 1'b0;
    #1;
    chk("abort_rd_req", dram_rd_req, 0);
    chk("abort_wr_req", dram_wr_req, 0);
    chk("abort_ic_val", ic_rd_val, 0);
    chk("abort_dcr_val", dc_rd_val, 0);
    chk("abort_dcw_val", dc_wr_val, 0);
    tick(); tick(); rst = 1'b1;
    wait_count(0, 16, 40, got);
    chk("abort_refill", got, 16);
    chk("abort_refill_end", dram_rd_req, 0);
    tick(); ic_rd_req = 0;
    repeat (6) tick();

    // Withdrawal after 2 words still completes all 16.
    ic_rd_req = 1; ic_rd_addr = 32'h700;
    wait_count(0, 2, 40, got);
    tick(); ic_rd_req = 0;
    wait_count(0, 14, 40, got);
    chk("withdraw_rest", got, 14);
    chk("withdraw_end", dram_rd_req, 0);
    repeat (6) tick();

    // Randomized traffic with random controller strobes.
    ic_cnt = 0; dr_cnt = 0; dw_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      dram_rd_val = ($urandom_range(9) < 7);
      dram_wr_val = ($urandom_range(9) < 7);
      if (seen_dcw) dc_wr_data = $urandom;
      if (!ic_rd_req) begin
        if ($urandom_range(3) == 0) begin ic_rd_req = 1; ic_rd_addr = $urandom; ic_cnt = 0; end
      end else begin
        if (seen_ic) ic_cnt++;
        if (ic_cnt >= 16 || $urandom_range(63) == 0) ic_rd_req = 0;
      end
      if (!dc_rd_req) begin
        if ($urandom_range(3) == 0) begin dc_rd_req = 1; dc_rd_addr = $urandom; dr_cnt = 0; end
      end else begin
        if (seen_dcr) dr_cnt++;
        if (dr_cnt >= 8 || $urandom_range(63) == 0) dc_rd_req = 0;
      end
      if (!dc_wr_req) begin
        if ($urandom_range(4) == 0) begin dc_wr_req = 1; dc_wr_addr = $urandom; dw_cnt = 0; end
      end else begin
        if (seen_dcw) dw_cnt++;
        if (dw_cnt >= 8 || $urandom_range(63) == 0) dc_wr_req = 0;
      end
    end
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    repeat (40) tick();

    summary();
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

endmodule
